simpleadder_collector: RTL
==========================

// Module: simpleadder_collector
// PURPOSE
//  Downstream stage of simpleadder: deserializes the adder's MSB-first serial result
//  (out/en_o) into parallel words and buffers them in a small FIFO.
//  Words leave on a valid/ready port to the checker/scoreboard logic.
//  Detects frames restarted mid-capture and words dropped on FIFO overflow.
// PARAMETERS
//  RES_WIDTH  3  result bits per frame, MSB first; legal range 2..8
//  DEPTH      4  FIFO entries; power of two, 2..16
// PORTS
//  clk        in   1                  single clock, all logic on posedge
//  rst        in   1                  asynchronous, active-high reset
//  ser_in     in   1                  serial result bit (adder out)
//  en_in      in   1                  frame start; high with MSB only (adder en_o)
//  res_data   out  RES_WIDTH          FIFO head word; valid only while res_valid=1
//  res_valid  out  1                  FIFO non-empty
//  res_ready  in   1                  consumer accepts head when res_valid&res_ready
//  fifo_level out  $clog2(DEPTH)+1    occupancy 0..DEPTH
//  overflow   out  1                  sticky: a completed word was dropped
//  restart_err out 1                  1-cycle pulse: en_in seen mid-frame
// BEHAVIOUR
//  Reset: state=IDLE, bit_cnt=0, shift reg=0, FIFO empty; res_data=0, res_valid=0,
//   fifo_level=0, overflow=0, restart_err=0. Reset mid-frame discards the partial word.
//  FSM IDLE: en_in=1 -> shreg<={..,ser_in}, bit_cnt=1, go SHIFT; else hold.
//   ser_in ignored in IDLE when en_in=0.
//  FSM SHIFT: each cycle shreg<={shreg[RES_WIDTH-2:0],ser_in}, bit_cnt++.
//   On the cycle bit_cnt==RES_WIDTH-1 the last bit is shifted in, the full word is
//   pushed and the FSM returns to IDLE.
//  en_in=1 while in SHIFT: partial word discarded, restart_err pulses next cycle,
//   current bit taken as MSB of a new frame (bit_cnt=1, stay SHIFT).
//   en_in on the last-bit cycle counts as a restart too: the word is not pushed.
//  Back-to-back frames: en_in may assert the cycle after the last bit (from IDLE).
//  Latency: last bit sampled at edge N -> word written at edge N; res_valid=1 and
//   res_data=word after edge N (if FIFO was empty).
//  FIFO: first-word-fall-through; res_data driven from head entry; pop on
//   res_valid&res_ready. fifo_level updates on the same edge as push/pop.
//  Full + push, no pop: word dropped, overflow set (sticky until rst), level stays DEPTH.
//  Full + push + pop same cycle: both happen, no drop, level stays DEPTH.
//  Empty + pop request: ignored (res_valid=0). Empty + push: res_valid next cycle.
//  Pointers wrap modulo DEPTH; level never exceeds DEPTH nor underflows.
// CONFIGURATION
//  SIMPLEADDER_COLLECTOR_CNT_EN defined: extra output frame_cnt [15:0], reset 0,
//   increments on every pushed word (including ones dropped to overflow), wraps
//   0xFFFF->0; aborted (restarted) frames not counted.
//  Not defined: port and counter absent; all other behaviour identical.
// TESTING
//  1 Reset: assert rst mid-frame -> all outputs 0, FIFO empty; next frame captured clean.
//  2 Single frame: en_in=1 with ser_in 1,0,1 on 3 cycles (3+2), res_ready=1 ->
//    res_valid high 1 cycle after last bit, res_data=3'b101, then popped, level 0.
//  3 Back-to-back: frames 101,011,110 with no gap, res_ready=0 -> level 3, pops in order.
//  4 Overflow: 5 frames, res_ready=0, DEPTH=4 -> level 4, overflow=1, 5th word absent;
//    repeat with pop on the 5th push cycle -> no drop, overflow stays 0.
//  5 Restart: en_in at bit 2 of a frame -> restart_err one pulse, new frame 110 yields
//    res_data=3'b110 only; aborted word never appears.
//  6 CNT_EN build: 70000 frames -> frame_cnt wraps to 70000-65536=4464.

Source files
------------

// File: rtl/simpleadder_collector_if.sv
// Collector port bundle: serial adder stream in, buffered parallel words out.
// Optional frame_cnt is present only when SIMPLEADDER_COLLECTOR_CNT_EN is defined.
interface simpleadder_collector_if #(
  parameter int RES_WIDTH = 3,
  parameter int DEPTH     = 4
);
  logic                   ser_in;
  logic                   en_in;
  logic [RES_WIDTH-1:0]   res_data;
  logic                   res_valid;
  logic                   res_ready;
  logic [$clog2(DEPTH):0] fifo_level;
  logic                   overflow;
  logic                   restart_err;
`ifdef SIMPLEADDER_COLLECTOR_CNT_EN
  logic [15:0]            frame_cnt;
`endif

  // master: the adder/consumer side driving the stream and accepting words
  modport master (
`ifdef SIMPLEADDER_COLLECTOR_CNT_EN
    input  frame_cnt,
`endif
    output ser_in, en_in, res_ready,
    input  res_data, res_valid, fifo_level, overflow, restart_err
  );

  // slave: the collector itself
  modport slave (
`ifdef SIMPLEADDER_COLLECTOR_CNT_EN
    output frame_cnt,
`endif
    input  ser_in, en_in, res_ready,
    output res_data, res_valid, fifo_level, overflow, restart_err
  );
endinterface

// File: rtl/simpleadder_collector.sv
// Deserialises MSB-first adder results into words and queues them in a FWFT FIFO (macro SIMPLEADDER_COLLECTOR_CNT_EN adds frame_cnt).
// Latency: word visible on res_data the cycle after its last bit is sampled (FIFO empty).
// Backpressure: res_ready stalls the FIFO; a word completing while full with no pop is dropped and sets sticky overflow.

module simpleadder_collector_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_push_dat,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_head,
  output logic                   o_valid,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_drop
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_wr;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LW'(DEPTH));
  assign w_pop   = i_pop & ~w_empty;
  // A pop on the same edge frees the slot the push needs, so full+push+pop is lossless
  assign w_wr    = i_push & (~w_full | w_pop);
  assign o_drop  = i_push & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_push_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= r_level + LW'(w_wr) - LW'(w_pop);
    end
  end

  assign o_valid = ~w_empty;
  assign o_head  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_level = r_level;
endmodule

module simpleadder_collector #(
  parameter int RES_WIDTH = 3,
  parameter int DEPTH     = 4
) (
  input  logic                clk,
  input  logic                rst,
  simpleadder_collector_if.slave bus
);
  localparam int CW = $clog2(RES_WIDTH);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [RES_WIDTH-1:0]   r_shreg;
  logic [RES_WIDTH-1:0]   w_shreg_nxt;
  logic [RES_WIDTH-1:0]   w_shift_val;
  logic [CW-1:0]          r_bit_cnt;
  logic [CW-1:0]          w_bit_cnt_nxt;
  logic                   w_push;
  logic                   w_restart;
  logic                   r_restart_err;
  logic                   r_overflow;
  logic                   w_drop;
  logic                   w_valid;
  logic [RES_WIDTH-1:0]   w_head;
  logic [$clog2(DEPTH):0] w_level;

  assign w_shift_val = {r_shreg[RES_WIDTH-2:0], bus.ser_in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_shreg       <= '0;
      r_bit_cnt     <= '0;
      r_restart_err <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_shreg       <= w_shreg_nxt;
      r_bit_cnt     <= w_bit_cnt_nxt;
      r_restart_err <= w_restart;
      r_overflow    <= r_overflow | w_drop;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_shreg_nxt   = r_shreg;
    w_bit_cnt_nxt = r_bit_cnt;
    w_push        = 1'b0;
    w_restart     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.en_in) begin
          w_shreg_nxt   = w_shift_val;
          w_bit_cnt_nxt = CW'(1);
          w_state_nxt   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_shreg_nxt = w_shift_val;
        // en_in wins over completion: even a last-bit restart discards the word
        if (bus.en_in) begin
          w_restart     = 1'b1;
          w_bit_cnt_nxt = CW'(1);
        end else if (r_bit_cnt == CW'(RES_WIDTH - 1)) begin
          w_push        = 1'b1;
          w_bit_cnt_nxt = '0;
          w_state_nxt   = S_IDLE;
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + CW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  simpleadder_collector_fifo #(
    .WIDTH (RES_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_dat (w_shift_val),
    .i_pop      (bus.res_ready),
    .o_head     (w_head),
    .o_valid    (w_valid),
    .o_level    (w_level),
    .o_drop     (w_drop)
  );

`ifdef SIMPLEADDER_COLLECTOR_CNT_EN
  logic [15:0] r_frame_cnt;

  // Counts completed words, including those lost to overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_frame_cnt <= '0;
    else if (w_push) r_frame_cnt <= r_frame_cnt + 16'd1;
  end

  assign bus.frame_cnt = r_frame_cnt;
`endif

  assign bus.res_data    = w_head;
  assign bus.res_valid   = w_valid;
  assign bus.fifo_level  = w_level;
  assign bus.overflow    = r_overflow;
  assign bus.restart_err = r_restart_err;
endmodule
